// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and helpers for the load/store unit.
package lsu_pkg;

  // RV32I funct3 values for loads and stores (stores use B/H/W only).
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Completion status codes reported on resp_fault.
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ACCESS   = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } lsu_state_e;

  // Convert between RISC-V (little-endian) and RAM (first byte in MSBs) word order.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
  function automatic logic funct3_legal(input logic store, input logic [2:0] f3);
    if (store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational data path: store byte-swap / sub-word merge and load extension.
// mem_word is the RAM word read at the request address (first byte in [31:24]).
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_word,
  output logic [31:0] store_word,
  output logic [31:0] load_word
);

  logic [7:0]  lo_byte;
  logic [15:0] lo_half;

  // Store merge keeps the untouched RAM bytes; load picks and extends the low bytes.
  always_comb begin
    lo_byte    = mem_word[31:24];
    lo_half    = {mem_word[23:16], mem_word[31:24]};
    store_word = bswap32(wdata);
    load_word  = '0;
    case (funct3)
      F3_B:    store_word = {wdata[7:0], mem_word[23:0]};
      F3_H:    store_word = {wdata[7:0], wdata[15:8], mem_word[15:0]};
      default: store_word = bswap32(wdata);
    endcase
    case (funct3)
      F3_B:    load_word = {{24{lo_byte[7]}}, lo_byte};
      F3_BU:   load_word = {24'd0, lo_byte};
      F3_H:    load_word = {{16{lo_half[15]}}, lo_half};
      F3_HU:   load_word = {16'd0, lo_half};
      F3_W:    load_word = bswap32(mem_word);
      default: load_word = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns execute-stage requests into word accesses on a
// RAM with one-cycle registered read data and word-only writes.
// Handshake: a request is accepted on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, and resp_valid is a single-cycle pulse in DONE.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_ADDR_BITS  = 11,
  parameter int CHIP_ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_write_en,
  input  logic [31:0] mem_dout,
  input  logic [(2**(MEM_ADDR_BITS-CHIP_ADDR_BITS))-1:0] mem_seg_faults,
  output logic [2:0]  dbg_state
);

  localparam int SEG_BITS = MEM_ADDR_BITS - CHIP_ADDR_BITS;

  lsu_state_e    state_q, state_d;
  logic          store_q, store_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   mem_din_q, mem_din_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    fault_q, fault_d;
  logic [1:0]    accept_fault;
  logic [31:0]   lane_store;
  logic [31:0]   lane_load;
  logic [SEG_BITS-1:0] seg_idx;

  assign seg_idx = addr_q[MEM_ADDR_BITS-1:CHIP_ADDR_BITS];

  lsu_byte_lane u_lane (
    .funct3     (funct3_q),
    .wdata      (wdata_q),
    .mem_word   (mem_dout),
    .store_word (lane_store),
    .load_word  (lane_load)
  );

  // Request checks in priority order: illegal funct3, misalignment, out of range.
  always_comb begin
    accept_fault = FAULT_NONE;
    if (!funct3_legal(req_store, req_funct3)) begin
      accept_fault = FAULT_ILLEGAL;
    end else if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                 (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)) begin
      accept_fault = FAULT_MISALIGN;
    end else if ((req_addr >> MEM_ADDR_BITS) != 32'd0) begin
      accept_fault = FAULT_ACCESS;
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    store_d   = store_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_din_d = mem_din_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          fault_d  = accept_fault;
          rdata_d  = '0;
          if (accept_fault != FAULT_NONE) begin
            state_d = DONE;
          end else if (req_store && req_funct3 == F3_W) begin
            // Full-word store needs no read: swap and write directly.
            mem_din_d = bswap32(req_wdata);
            state_d   = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        // mem_dout now holds the word addressed during RD.
        if (store_q) begin
          mem_din_d = lane_store;
          state_d   = WR;
        end else begin
          rdata_d = lane_load;
          state_d = DONE;
        end
      end
      WR: begin
        // The write still happens; a flagged chip turns it into an access fault.
        if (mem_seg_faults[seg_idx]) fault_d = FAULT_ACCESS;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      store_q   <= 1'b0;
      funct3_q  <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_din_q <= '0;
      rdata_q   <= '0;
      fault_q   <= FAULT_NONE;
    end else begin
      state_q   <= state_d;
      store_q   <= store_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mem_din_q <= mem_din_d;
      rdata_q   <= rdata_d;
      fault_q   <= fault_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == DONE);
  assign mem_write_en = (state_q == WR);
  assign resp_rdata   = rdata_q;
  assign resp_fault   = fault_q;
  assign mem_addr     = addr_q;
  assign mem_din      = mem_din_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit paired with an 8-chip, 2 KiB byte-addressed RAM.
// Expected results come from a little-endian byte-array reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_write_en;
  logic [31:0] mem_dout;
  logic [7:0]  mem_seg_faults;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int txn   = 0;

  logic [7:0]  ram     [2048];
  logic [7:0]  ref_mem [2048];
  logic [31:0] exp_q[$];

  load_store_unit #(.MEM_ADDR_BITS(11), .CHIP_ADDR_BITS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_store      (req_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_fault     (resp_fault),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_write_en   (mem_write_en),
    .mem_dout       (mem_dout),
    .mem_seg_faults (mem_seg_faults),
    .dbg_state      (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // RAM model: byte at address A in [31:24], wraps within 2 KiB, cleared by rst.
  wire [10:0] ra = mem_addr[10:0];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2048; i++) ram[i] <= 8'h00;
      mem_dout <= 32'h0;
    end else begin
      if (mem_write_en) begin
        ram[ra]          <= mem_din[31:24];
        ram[ra + 11'd1]  <= mem_din[23:16];
        ram[ra + 11'd2]  <= mem_din[15:8];
        ram[ra + 11'd3]  <= mem_din[7:0];
      end
      mem_dout <= {ram[ra], ram[ra + 11'd1], ram[ra + 11'd2], ram[ra + 11'd3]};
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic report_fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_bad++;
    $error("FAIL %s (txn %0d): observed %0h, expected %0h", tag, txn, obs, exp);
  endtask

  // One request, called at a falling edge with the DUT idle; returns at the
  // falling edge of the following idle cycle so calls run back to back.
  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] got);
    bit          legal;
    int          nbytes;
    logic [1:0]  ef;
    logic [31:0] erd;
    logic [31:0] exp_rd;
    int          elat;
    int          ewr;
    int          lat;
    int          wr_cnt;
    bit          seen;
    logic [10:0] idx;
    txn++;
    // Reference model
    legal  = st ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    erd    = 32'h0;
    if (!legal)                 ef = 2'd3;
    else if (a % nbytes != 0)   ef = 2'd1;
    else if (a >= 32'd2048)     ef = 2'd2;
    else                        ef = 2'd0;
    if (ef != 2'd0) begin
      elat = 1;
      ewr  = 0;
    end else if (st) begin
      elat = (nbytes == 4) ? 2 : 4;
      ewr  = 1;
      for (int i = 0; i < nbytes; i++) begin
        idx = 11'(a + i);
        ref_mem[idx] = wd[8*i +: 8];
      end
      if (mem_seg_faults[a[10:8]]) ef = 2'd2;
    end else begin
      elat = 3;
      ewr  = 0;
      for (int i = 0; i < nbytes; i++) begin
        idx = 11'(a + i);
        erd[8*i +: 8] = ref_mem[idx];
      end
      if (f3[2] == 1'b0 && nbytes == 1) erd = {{24{erd[7]}}, erd[7:0]};
      if (f3[2] == 1'b0 && nbytes == 2) erd = {{16{erd[15]}}, erd[15:0]};
    end
    exp_q.push_back(erd);
    // Drive
    n_cmp++;
    if (req_ready !== 1'b1) report_fail("ready_before_req", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat    = 0;
    wr_cnt = 0;
    seen   = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (mem_write_en) wr_cnt++;
      if (resp_valid) seen = 1'b1;
    end
    got = resp_rdata;
    n_cmp++;
    if (seen !== 1'b1) report_fail("resp_seen", seen, 1'b1);
    n_cmp++;
    if (lat != elat) report_fail("latency", lat, elat);
    n_cmp++;
    if (wr_cnt != ewr) report_fail("write_cycles", wr_cnt, ewr);
    n_cmp++;
    if (resp_fault !== ef) report_fail("resp_fault", resp_fault, ef);
    exp_rd = exp_q.pop_front();
    n_cmp++;
    if (resp_rdata !== exp_rd) report_fail("resp_rdata", resp_rdata, exp_rd);
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b0) report_fail("resp_single_pulse", resp_valid, 1'b0);
    n_cmp++;
    if (req_ready !== 1'b1) report_fail("ready_after_done", req_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    logic [2:0]  f3;
    bit          st;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_store      = 1'b0;
    req_funct3     = 3'd0;
    req_addr       = 32'h0;
    req_wdata      = 32'h0;
    mem_seg_faults = 8'b0000_1000;  // chip 3 (0x300-0x3FF) flagged

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) report_fail("rst_req_ready", req_ready, 1'b1);
    n_cmp++;
    if (resp_valid !== 1'b0) report_fail("rst_resp_valid", resp_valid, 1'b0);
    n_cmp++;
    if (resp_rdata !== 32'h0) report_fail("rst_resp_rdata", resp_rdata, 32'h0);
    n_cmp++;
    if (resp_fault !== 2'b00) report_fail("rst_resp_fault", resp_fault, 2'b00);
    n_cmp++;
    if (mem_addr !== 32'h0) report_fail("rst_mem_addr", mem_addr, 32'h0);
    n_cmp++;
    if (mem_din !== 32'h0) report_fail("rst_mem_din", mem_din, 32'h0);
    n_cmp++;
    if (mem_write_en !== 1'b0) report_fail("rst_mem_write_en", mem_write_en, 1'b0);
    rst = 1'b0;

    // SW then LW, byte order in RAM
    do_req(1'b1, 3'b010, 32'h010, 32'h11223344, got);
    n_cmp++;
    if (ram[16] !== 8'h44) report_fail("ram_10", ram[16], 8'h44);
    n_cmp++;
    if (ram[17] !== 8'h33) report_fail("ram_11", ram[17], 8'h33);
    n_cmp++;
    if (ram[18] !== 8'h22) report_fail("ram_12", ram[18], 8'h22);
    n_cmp++;
    if (ram[19] !== 8'h11) report_fail("ram_13", ram[19], 8'h11);
    do_req(1'b0, 3'b010, 32'h010, 32'h0, got);
    n_cmp++;
    if (got !== 32'h11223344) report_fail("lw_after_sw", got, 32'h11223344);

    // SB merge leaves neighbours unchanged
    do_req(1'b1, 3'b000, 32'h011, 32'h000000AB, got);
    do_req(1'b0, 3'b010, 32'h010, 32'h0, got);
    n_cmp++;
    if (got !== 32'h1122AB44) report_fail("lw_after_sb", got, 32'h1122AB44);
    n_cmp++;
    if (ram[18] !== 8'h22) report_fail("ram_12_kept", ram[18], 8'h22);
    n_cmp++;
    if (ram[19] !== 8'h11) report_fail("ram_13_kept", ram[19], 8'h11);

    // Sign/zero extension
    do_req(1'b1, 3'b000, 32'h020, 32'hDEADBE80, got);
    do_req(1'b1, 3'b000, 32'h021, 32'h123456FF, got);
    do_req(1'b0, 3'b000, 32'h020, 32'h0, got);
    n_cmp++;
    if (got !== 32'hFFFFFF80) report_fail("lb_20", got, 32'hFFFFFF80);
    do_req(1'b0, 3'b100, 32'h020, 32'h0, got);
    n_cmp++;
    if (got !== 32'h00000080) report_fail("lbu_20", got, 32'h00000080);
    do_req(1'b0, 3'b001, 32'h020, 32'h0, got);
    n_cmp++;
    if (got !== 32'hFFFFFF80) report_fail("lh_20", got, 32'hFFFFFF80);
    do_req(1'b0, 3'b101, 32'h020, 32'h0, got);
    n_cmp++;
    if (got !== 32'h0000FF80) report_fail("lhu_20", got, 32'h0000FF80);

    // Faults
    do_req(1'b0, 3'b001, 32'h013, 32'h0, got);
    n_cmp++;
    if (resp_fault !== 2'b01) report_fail("lh_13_fault", resp_fault, 2'b01);
    do_req(1'b1, 3'b010, 32'h802, 32'h55667788, got);
    do_req(1'b1, 3'b010, 32'h800, 32'h55667788, got);
    do_req(1'b0, 3'b011, 32'h010, 32'h0, got);
    do_req(1'b1, 3'b100, 32'h010, 32'h0, got);
    do_req(1'b1, 3'b010, 32'h304, 32'hCAFEF00D, got);
    do_req(1'b1, 3'b001, 32'h30A, 32'h0000BEEF, got);
    do_req(1'b0, 3'b010, 32'h304, 32'h0, got);
    n_cmp++;
    if (got !== 32'hCAFEF00D) report_fail("lw_seg_written", got, 32'hCAFEF00D);

    // Reset during the WR cycle of an SW
    txn++;
    n_cmp++;
    if (req_ready !== 1'b1) report_fail("abort_ready", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h040;
    req_wdata  = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_write_en !== 1'b1) report_fail("abort_in_wr", mem_write_en, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
    n_cmp++;
    if (resp_valid !== 1'b0) report_fail("abort_no_resp", resp_valid, 1'b0);
    n_cmp++;
    if (req_ready !== 1'b1) report_fail("abort_ready_next", req_ready, 1'b1);
    n_cmp++;
    if (mem_write_en !== 1'b0) report_fail("abort_we_low", mem_write_en, 1'b0);
    do_req(1'b0, 3'b010, 32'h010, 32'h0, got);
    n_cmp++;
    if (got !== 32'h0) report_fail("lw_after_clear", got, 32'h0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 19))
        0:       a = $urandom;
        1:       a = 32'h800 + $urandom_range(0, 255);
        default: a = $urandom_range(0, 2047);
      endcase
      do_req(st, f3, a, $urandom, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
